// File: rtl/issue_stage.sv
// ---------------------------------------------------------------------------
// issue_stage
//
// Takes one decoded instruction per cycle, allocates a ROB entry for it,
// renames its destination, resolves both source operands, and holds the result
// in an output register. The entry stays there until the reservation station
// or the load/store buffer accepts it.
//
// An operand comes from the first source below that can supply it:
//   1. the register file, when its tag is 0 (value already architectural)
//   2. the ROB value port
//   3. one of the result buses (CDBs); a lower bus index has higher priority
// If none of these has the value, the operand keeps its ROB tag. A held entry
// keeps snooping the buses, so a broadcast that arrives during a stall is kept.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rdy                        global enable; when low, all state is frozen
//   flush                      misprediction flush (synchronous)
//   in_*                       decoded instruction plus valid/ready handshake
//   rs*_to_rf, vj/qj/vk/qk_rf  register file read (value + rename tag)
//   q*_to_rob, rob_v*          ROB lookup of finished values
//   rob_full/tag/alloc/...     ROB allocation
//   rf_rename_*                register file rename request
//   bus_valid/tag/value        result buses, bus i in slice i
//   out_*                      held entry toward the RS (out_to_lsb=0) or LSB
// ---------------------------------------------------------------------------
module issue_stage #(
    parameter int XLEN    = 32,
    parameter int ROB_IDW = 4,
    parameter int NUM_BUS = 2,
    parameter int OPW     = 6,
    parameter int IMMW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       flush,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_kind,
    input  logic [OPW-1:0]             in_op,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [IMMW-1:0]            in_imm,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_next_pc,

    output logic [4:0]                 rs1_to_rf,
    output logic [4:0]                 rs2_to_rf,
    input  logic [XLEN-1:0]            vj_rf,
    input  logic [ROB_IDW-1:0]         qj_rf,
    input  logic [XLEN-1:0]            vk_rf,
    input  logic [ROB_IDW-1:0]         qk_rf,

    output logic [ROB_IDW-1:0]         qj_to_rob,
    output logic [ROB_IDW-1:0]         qk_to_rob,
    input  logic                       rob_vj_valid,
    input  logic [XLEN-1:0]            rob_vj,
    input  logic                       rob_vk_valid,
    input  logic [XLEN-1:0]            rob_vk,
    input  logic                       rob_full,
    input  logic [ROB_IDW-1:0]         rob_tag,
    output logic                       rob_alloc,
    output logic [1:0]                 rob_kind,
    output logic [4:0]                 rob_rd,
    output logic [XLEN-1:0]            rob_next_pc,

    output logic [4:0]                 rf_rename_rd,
    output logic [ROB_IDW-1:0]         rf_rename_tag,

    input  logic [NUM_BUS-1:0]         bus_valid,
    input  logic [NUM_BUS*ROB_IDW-1:0] bus_tag,
    input  logic [NUM_BUS*XLEN-1:0]    bus_value,

    output logic                       out_valid,
    output logic                       out_to_lsb,
    input  logic                       out_ready,
    output logic [ROB_IDW-1:0]         out_dest,
    output logic [OPW-1:0]             out_op,
    output logic [ROB_IDW-1:0]         out_qj,
    output logic [XLEN-1:0]            out_vj,
    output logic [ROB_IDW-1:0]         out_qk,
    output logic [XLEN-1:0]            out_vk,
    output logic [IMMW-1:0]            out_imm,
    output logic [XLEN-1:0]            out_pc
);

    logic                accept;
    logic [XLEN:0]       bus_j_in;
    logic [XLEN:0]       bus_k_in;
    logic [XLEN:0]       bus_j_held;
    logic [XLEN:0]       bus_k_held;
    logic [ROB_IDW-1:0]  res_qj;
    logic [XLEN-1:0]     res_vj;
    logic [ROB_IDW-1:0]  res_qk;
    logic [XLEN-1:0]     res_vk;

    // Returns {hit, value} for the lowest-index valid bus that carries tag.
    // The loop scans from the highest index down, so the lowest matching bus
    // is assigned last and wins. Tag 0 means "no dependency", so it never hits.
    function automatic logic [XLEN:0] bus_lookup(input logic [ROB_IDW-1:0] tag);
        logic [XLEN:0] hit;
        hit = '0;
        for (int i = NUM_BUS - 1; i >= 0; i--) begin
            if (bus_valid[i] && (tag != '0) && (bus_tag[i*ROB_IDW +: ROB_IDW] == tag))
                hit = {1'b1, bus_value[i*XLEN +: XLEN]};
        end
        return hit;
    endfunction

    // The output slot can take a new entry when it is empty, or when the
    // current entry leaves on this same edge. This is what allows one issue
    // per cycle when the downstream side never stalls.
    assign in_ready      = rdy & ~flush & ~rob_full & (~out_valid | out_ready);
    assign accept        = in_valid & in_ready;
    assign rob_alloc     = accept;

    assign rs1_to_rf     = in_rs1;
    assign rs2_to_rf     = in_rs2;
    assign qj_to_rob     = qj_rf;
    assign qk_to_rob     = qk_rf;
    assign rob_kind      = in_kind;
    assign rob_rd        = in_rd;
    assign rob_next_pc   = in_next_pc;
    assign rf_rename_tag = rob_tag;

    // Only normal ops and loads write a register. Register x0 is never renamed.
    assign rf_rename_rd  = (accept && (in_kind == 2'd0 || in_kind == 2'd2) && in_rd != 5'd0)
                           ? in_rd : 5'd0;

    assign bus_j_in      = bus_lookup(qj_rf);
    assign bus_k_in      = bus_lookup(qk_rf);
    assign bus_j_held    = bus_lookup(out_qj);
    assign bus_k_held    = bus_lookup(out_qk);

    // Operand resolution for the incoming instruction. The order is:
    // register file, then ROB, then buses, then leave the tag pending.
    always_comb begin
        res_qj = qj_rf;
        res_vj = vj_rf;
        if (qj_rf == '0) begin
            res_qj = '0;
        end else if (rob_vj_valid) begin
            res_qj = '0;
            res_vj = rob_vj;
        end else if (bus_j_in[XLEN]) begin
            res_qj = '0;
            res_vj = bus_j_in[XLEN-1:0];
        end

        res_qk = qk_rf;
        res_vk = vk_rf;
        if (qk_rf == '0) begin
            res_qk = '0;
        end else if (rob_vk_valid) begin
            res_qk = '0;
            res_vk = rob_vk;
        end else if (bus_k_in[XLEN]) begin
            res_qk = '0;
            res_vk = bus_k_in[XLEN-1:0];
        end
    end

    // Output register. Priority is flush, then accept, then fire, then snoop.
    // An accept can only happen when the slot is empty or is firing, so a new
    // entry never overwrites one that is still waiting. While rdy is low,
    // nothing changes, and that includes flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_to_lsb <= 1'b0;
            out_dest   <= '0;
            out_op     <= '0;
            out_qj     <= '0;
            out_vj     <= '0;
            out_qk     <= '0;
            out_vk     <= '0;
            out_imm    <= '0;
            out_pc     <= '0;
        end else if (rdy) begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_to_lsb <= in_kind[1];
                out_dest   <= rob_tag;
                out_op     <= in_op;
                out_qj     <= res_qj;
                out_vj     <= res_vj;
                out_qk     <= res_qk;
                out_vk     <= res_vk;
                out_imm    <= in_imm;
                out_pc     <= in_pc;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end else if (out_valid) begin
                if (bus_j_held[XLEN]) begin
                    out_qj <= '0;
                    out_vj <= bus_j_held[XLEN-1:0];
                end
                if (bus_k_held[XLEN]) begin
                    out_qk <= '0;
                    out_vk <= bus_k_held[XLEN-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_issue_stage
//
// Self-checking bench for issue_stage with the default parameters.
//
// Each expected entry is pushed to a scoreboard queue when the instruction is
// driven. The entry carries its final operand values, including values that
// arrive later by snooping the buses. A monitor runs on the falling edge. When
// the DUT presents an entry that will fire, the monitor pops the oldest
// expected entry and compares every field against it. Entries that are
// flushed or reset away are never pushed.
// ---------------------------------------------------------------------------
module tb_issue_stage;

    typedef struct {
        logic [3:0]  dest;
        logic [5:0]  op;
        logic [3:0]  qj;
        logic [31:0] vj;
        logic [3:0]  qk;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        to_lsb;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [5:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic [31:0] in_next_pc;
    logic [4:0]  rs1_to_rf;
    logic [4:0]  rs2_to_rf;
    logic [31:0] vj_rf;
    logic [3:0]  qj_rf;
    logic [31:0] vk_rf;
    logic [3:0]  qk_rf;
    logic [3:0]  qj_to_rob;
    logic [3:0]  qk_to_rob;
    logic        rob_vj_valid;
    logic [31:0] rob_vj;
    logic        rob_vk_valid;
    logic [31:0] rob_vk;
    logic        rob_full;
    logic [3:0]  rob_tag;
    logic        rob_alloc;
    logic [1:0]  rob_kind;
    logic [4:0]  rob_rd;
    logic [31:0] rob_next_pc;
    logic [4:0]  rf_rename_rd;
    logic [3:0]  rf_rename_tag;
    logic [1:0]  bus_valid;
    logic [7:0]  bus_tag;
    logic [63:0] bus_value;
    logic        out_valid;
    logic        out_to_lsb;
    logic        out_ready;
    logic [3:0]  out_dest;
    logic [5:0]  out_op;
    logic [3:0]  out_qj;
    logic [31:0] out_vj;
    logic [3:0]  out_qk;
    logic [31:0] out_vk;
    logic [31:0] out_imm;
    logic [31:0] out_pc;

    int     errors = 0;
    int     checks = 0;
    int     pops   = 0;
    entry_t sb[$];

    issue_stage dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_pc(in_pc), .in_next_pc(in_next_pc),
        .rs1_to_rf(rs1_to_rf), .rs2_to_rf(rs2_to_rf),
        .vj_rf(vj_rf), .qj_rf(qj_rf), .vk_rf(vk_rf), .qk_rf(qk_rf),
        .qj_to_rob(qj_to_rob), .qk_to_rob(qk_to_rob),
        .rob_vj_valid(rob_vj_valid), .rob_vj(rob_vj),
        .rob_vk_valid(rob_vk_valid), .rob_vk(rob_vk),
        .rob_full(rob_full), .rob_tag(rob_tag), .rob_alloc(rob_alloc),
        .rob_kind(rob_kind), .rob_rd(rob_rd), .rob_next_pc(rob_next_pc),
        .rf_rename_rd(rf_rename_rd), .rf_rename_tag(rf_rename_tag),
        .bus_valid(bus_valid), .bus_tag(bus_tag), .bus_value(bus_value),
        .out_valid(out_valid), .out_to_lsb(out_to_lsb), .out_ready(out_ready),
        .out_dest(out_dest), .out_op(out_op), .out_qj(out_qj), .out_vj(out_vj),
        .out_qk(out_qk), .out_vk(out_vk), .out_imm(out_imm), .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit, so the run always ends even if the stimulus gets stuck.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation still running at time %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Return all inputs to idle. rst_n, rdy and out_ready are left unchanged.
    task automatic idleInputs();
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_kind      = 2'd0;
        in_op        = '0;
        in_rd        = '0;
        in_rs1       = '0;
        in_rs2       = '0;
        in_imm       = '0;
        in_pc        = '0;
        in_next_pc   = '0;
        vj_rf        = '0;
        qj_rf        = '0;
        vk_rf        = '0;
        qk_rf        = '0;
        rob_vj_valid = 1'b0;
        rob_vj       = '0;
        rob_vk_valid = 1'b0;
        rob_vk       = '0;
        rob_full     = 1'b0;
        rob_tag      = '0;
        bus_valid    = '0;
        bus_tag      = '0;
        bus_value    = '0;
    endtask

    // Drive one decoded instruction. The ROB ports default to "value not
    // finished", and the buses are left as they are.
    task automatic applyStimulus(input logic [1:0] kind, input logic [4:0] rd,
                                 input logic [3:0] tag, input logic [3:0] qj,
                                 input logic [31:0] vj, input logic [3:0] qk,
                                 input logic [31:0] vk, input logic [31:0] pc);
        in_valid   = 1'b1;
        in_kind    = kind;
        in_op      = 6'h20 + {2'b00, tag};
        in_rd      = rd;
        in_rs1     = rd + 5'd1;
        in_rs2     = rd + 5'd2;
        in_imm     = pc ^ 32'h0000_F0F0;
        in_pc      = pc;
        in_next_pc = pc + 32'd4;
        rob_tag    = tag;
        qj_rf      = qj;
        vj_rf      = vj;
        qk_rf      = qk;
        vk_rf      = vk;
    endtask

    function automatic entry_t mkEntry(input logic [3:0] dest, input logic [3:0] qj,
                                       input logic [31:0] vj, input logic [3:0] qk,
                                       input logic [31:0] vk, input logic [31:0] pc,
                                       input logic to_lsb);
        entry_t e;
        e.dest   = dest;
        e.op     = 6'h20 + {2'b00, dest};
        e.qj     = qj;
        e.vj     = vj;
        e.qk     = qk;
        e.vk     = vk;
        e.imm    = pc ^ 32'h0000_F0F0;
        e.pc     = pc;
        e.to_lsb = to_lsb;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor. An entry that is valid and ready at the falling edge
    // leaves on the next rising edge, so it is compared now.
    always @(negedge clk) begin
        if (rst_n && rdy && !flush && out_valid && out_ready) begin
            checkOutput("sb_nonempty_on_fire", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                entry_t e;
                e = sb.pop_front();
                pops++;
                checkOutput("out_dest",   out_dest,   e.dest);
                checkOutput("out_op",     out_op,     e.op);
                checkOutput("out_qj",     out_qj,     e.qj);
                checkOutput("out_vj",     out_vj,     e.vj);
                checkOutput("out_qk",     out_qk,     e.qk);
                checkOutput("out_vk",     out_vk,     e.vk);
                checkOutput("out_imm",    out_imm,    e.imm);
                checkOutput("out_pc",     out_pc,     e.pc);
                checkOutput("out_to_lsb", out_to_lsb, e.to_lsb);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        rdy       = 1'b1;
        out_ready = 1'b0;
        idleInputs();

        // Reset state
        #12;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_dest",  out_dest,  0);
        checkOutput("rst_out_vj",    out_vj,    0);
        checkOutput("rst_in_ready",  in_ready,  1);
        checkOutput("rst_rob_alloc", rob_alloc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Normal op with both operands ready in the register file
        applyStimulus(2'd0, 5'd7, 4'd3, 4'd0, 32'd5, 4'd0, 32'd7, 32'h1000);
        #1;
        checkOutput("t1_rob_alloc",     rob_alloc,     1);
        checkOutput("t1_rename_rd",     rf_rename_rd,  7);
        checkOutput("t1_rename_tag",    rf_rename_tag, 3);
        checkOutput("t1_rs1_to_rf",     rs1_to_rf,     8);
        checkOutput("t1_rob_next_pc",   rob_next_pc,   32'h1004);
        sb.push_back(mkEntry(4'd3, 4'd0, 32'd5, 4'd0, 32'd7, 32'h1000, 1'b0));
        step();
        idleInputs();
        checkOutput("t1_out_valid",  out_valid,  1);
        checkOutput("t1_out_to_lsb", out_to_lsb, 0);
        out_ready = 1'b1;
        step();
        checkOutput("t1_drained", out_valid, 0);

        // Two buses hit the same tag: bus 0 must win. Operand k comes from the ROB.
        applyStimulus(2'd0, 5'd0, 4'd5, 4'd2, 32'hDEAD, 4'd6, 32'hBEEF, 32'h2000);
        bus_valid    = 2'b11;
        bus_tag      = {4'd2, 4'd2};
        bus_value    = {32'hAA, 32'h55};
        rob_vk_valid = 1'b1;
        rob_vk       = 32'h77;
        #1;
        checkOutput("t2_rob_alloc", rob_alloc,    1);
        checkOutput("t2_rename_x0", rf_rename_rd, 0);
        sb.push_back(mkEntry(4'd5, 4'd0, 32'h55, 4'd0, 32'h77, 32'h2000, 1'b0));
        step();
        idleInputs();
        step();

        // Store with an unresolved k operand that is caught while the entry is held
        out_ready = 1'b0;
        applyStimulus(2'd3, 5'd9, 4'd7, 4'd0, 32'h10, 4'd4, 32'hDEAD, 32'h3000);
        #1;
        checkOutput("t3_rob_alloc",   rob_alloc,    1);
        checkOutput("t3_store_no_rn", rf_rename_rd, 0);
        sb.push_back(mkEntry(4'd7, 4'd0, 32'h10, 4'd0, 32'd9, 32'h3000, 1'b1));
        step();
        idleInputs();
        checkOutput("t3_out_to_lsb",  out_to_lsb, 1);
        checkOutput("t3_qk_pending",  out_qk,     4);
        checkOutput("t3_vk_pending",  out_vk,     32'hDEAD);
        in_valid  = 1'b1;
        rob_tag   = 4'd8;
        bus_valid = 2'b01;
        bus_tag   = {4'd0, 4'd4};
        bus_value = {32'd0, 32'd9};
        #1;
        checkOutput("t3_stall_in_ready", in_ready,  0);
        checkOutput("t3_stall_no_alloc", rob_alloc, 0);
        step();
        idleInputs();
        checkOutput("t3_snoop_qk", out_qk, 0);
        checkOutput("t3_snoop_vk", out_vk, 9);
        bus_valid = 2'b01;
        bus_tag   = {4'd0, 4'd0};
        bus_value = {32'd0, 32'h123};
        step();
        idleInputs();
        checkOutput("t3_tag0_ignored", out_vk, 9);
        out_ready = 1'b1;
        step();

        // Back-to-back issue, then ROB full
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'd0, 5'(i + 1), 4'(8 + i), 4'd0, 32'(100 + i), 4'd0, 32'(200 + i),
                          32'h4000 + 32'(i * 4));
            #1;
            checkOutput("t4_rob_alloc", rob_alloc, 1);
            sb.push_back(mkEntry(4'(8 + i), 4'd0, 32'(100 + i), 4'd0, 32'(200 + i),
                                 32'h4000 + 32'(i * 4), 1'b0));
            step();
            checkOutput("t4_no_bubble", out_valid, 1);
        end
        idleInputs();
        in_valid = 1'b1;
        rob_full = 1'b1;
        rob_tag  = 4'd12;
        #1;
        checkOutput("t4_full_in_ready", in_ready,  0);
        checkOutput("t4_full_no_alloc", rob_alloc, 0);
        step();
        idleInputs();
        checkOutput("t4_drained", out_valid, 0);
        checkOutput("t4_pop_count", pops, 7);

        // Flush while an entry is held and a new instruction is offered
        out_ready = 1'b0;
        applyStimulus(2'd0, 5'd3, 4'd12, 4'd0, 32'd1, 4'd0, 32'd2, 32'h5000);
        step();
        applyStimulus(2'd0, 5'd4, 4'd13, 4'd0, 32'd1, 4'd0, 32'd2, 32'h5004);
        flush = 1'b1;
        #1;
        checkOutput("t5_flush_no_alloc",  rob_alloc,    0);
        checkOutput("t5_flush_in_ready",  in_ready,     0);
        checkOutput("t5_flush_no_rename", rf_rename_rd, 0);
        step();
        idleInputs();
        checkOutput("t5_flush_clears", out_valid, 0);

        // Asynchronous reset in the middle of a stall
        applyStimulus(2'd2, 5'd5, 4'd13, 4'd0, 32'd1, 4'd0, 32'd2, 32'h6000);
        step();
        idleInputs();
        checkOutput("t5_held", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_valid", out_valid, 0);
        checkOutput("t5_async_dest",  out_dest,  0);
        checkOutput("t5_async_pc",    out_pc,    0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // rdy low freezes everything, flush included. Once rdy is high again,
        // only a bus that is still valid gets snooped.
        applyStimulus(2'd0, 5'd6, 4'd14, 4'd13, 32'd1, 4'd15, 32'd2, 32'h7000);
        sb.push_back(mkEntry(4'd14, 4'd0, 32'h31, 4'd15, 32'd2, 32'h7000, 1'b0));
        step();
        idleInputs();
        checkOutput("t6_qj_pending", out_qj, 13);
        checkOutput("t6_qk_pending", out_qk, 15);
        rdy       = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        rob_tag   = 4'd1;
        bus_valid = 2'b11;
        bus_tag   = {4'd15, 4'd13};
        bus_value = {32'h44, 32'h31};
        #1;
        checkOutput("t6_frozen_in_ready", in_ready,  0);
        checkOutput("t6_frozen_no_alloc", rob_alloc, 0);
        step();
        checkOutput("t6_frozen_valid", out_valid, 1);
        checkOutput("t6_frozen_qj",    out_qj,    13);
        checkOutput("t6_frozen_vj",    out_vj,    1);
        rdy       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        bus_valid = 2'b01;
        step();
        idleInputs();
        checkOutput("t6_snoop_qj", out_qj, 0);
        checkOutput("t6_snoop_vj", out_vj, 32'h31);
        checkOutput("t6_stale_qk", out_qk, 15);
        checkOutput("t6_stale_vk", out_vk, 2);
        out_ready = 1'b1;
        step();
        checkOutput("t6_drained", out_valid, 0);

        checkOutput("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Parametrised, handshaked successor to the single-cycle issuer: accepts one decoded instruction per cycle, renames it, resolves operands, and holds the result in an output register until the RS or LSB accepts it.
- Resolves operands from the reg file, the ROB value port, and N result buses (CDBs).
- A held entry keeps snooping the buses, so a broadcast that arrives during a stall is never lost.
- Sits between the decoder/inst fetcher and the reservation station, load/store buffer, ROB and reg file.

Parameters:
XLEN, 32, data/PC width
ROB_IDW, 4, ROB tag width; tag 0 = "no dependency/invalid"
NUM_BUS, 2, number of result buses; lower index has higher priority
OPW, 6, op code width
IMMW, 32, immediate width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
rdy  in  1  global enable; low = freeze all state, in_ready=0
flush  in  1  ROB misprediction reset, synchronous
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage accepts this cycle
in_kind  in  2  0 normal, 1 branch, 2 load, 3 store
in_op  in  OPW  op code
in_rd  in  5  destination reg
in_rs1  in  5  source reg 1
in_rs2  in  5  source reg 2
in_imm  in  IMMW  immediate
in_pc  in  XLEN  instruction PC
in_next_pc  in  XLEN  predicted next PC
rs1_to_rf  out  5  = in_rs1
rs2_to_rf  out  5  = in_rs2
vj_rf  in  XLEN  reg file value 1
qj_rf  in  ROB_IDW  reg file tag 1
vk_rf  in  XLEN  reg file value 2
qk_rf  in  ROB_IDW  reg file tag 2
qj_to_rob  out  ROB_IDW  = qj_rf
qk_to_rob  out  ROB_IDW  = qk_rf
rob_vj_valid  in  1  ROB holds finished value for qj
rob_vj  in  XLEN  that value
rob_vk_valid  in  1  ROB holds finished value for qk
rob_vk  in  XLEN  that value
rob_full  in  1  ROB cannot allocate
rob_tag  in  ROB_IDW  tag allocated on accept (nonzero)
rob_alloc  out  1  accept pulse
rob_kind  out  2  = in_kind
rob_rd  out  5  = in_rd
rob_next_pc  out  XLEN  = in_next_pc
rf_rename_rd  out  5  reg to rename; 0 = none
rf_rename_tag  out  ROB_IDW  = rob_tag
bus_valid  in  NUM_BUS  per-bus broadcast valid
bus_tag  in  NUM_BUS*ROB_IDW  per-bus tags, bus i at [i*ROB_IDW +: ROB_IDW]
bus_value  in  NUM_BUS*XLEN  per-bus values
out_valid  out  1  held entry valid
out_to_lsb  out  1  1 = entry targets LSB (load/store), 0 = RS
out_ready  in  1  ready from the target selected by out_to_lsb
out_dest, out_op, out_qj, out_vj, out_qk, out_vk, out_imm, out_pc  out  ROB_IDW/OPW/ROB_IDW/XLEN/ROB_IDW/XLEN/IMMW/XLEN  entry fields

Behaviour:
- Reset (rst_n=0, async): out_valid=0; all out_* fields 0. Combinational outputs follow their equations.
- in_ready = rdy & !flush & !rob_full & (!out_valid | out_ready).
- accept = in_valid & in_ready.
- rob_alloc = accept (combinational).
- rf_rename_rd = accept & (in_kind==0 | in_kind==2) & in_rd!=0 ? in_rd : 0. Branch/store never rename.
- Operand resolution per source (j shown; k identical):
  - qj_rf==0 -> vj_rf, tag 0.
  - else rob_vj_valid -> rob_vj, tag 0.
  - else lowest i with bus_valid[i] & bus_tag[i]==qj_rf -> bus_value[i], tag 0.
  - else vj_rf, tag qj_rf.
- On accept, the output register loads in the next edge (latency 1):
  - out_valid=1, out_to_lsb=(in_kind>=2), out_dest=rob_tag;
  - resolved q/v, op, imm, pc.
- Held entry (out_valid & !out_ready, no flush): each nonzero out_qj/out_qk matching the lowest-index valid bus loads that bus value and clears the tag. Other fields are stable.
- Output fire (out_valid & out_ready) without accept: out_valid<=0 next edge.
- Fire and accept in the same cycle: the new entry replaces the old one, giving back-to-back throughput of 1/cycle.
- flush=1: out_valid<=0, no accept, no rob_alloc; flush overrides fire, accept and snoop.
- rdy=0: no register updates, no accept; flush is ignored while rdy=0.
- Bus tag 0 never matches (bus_valid with tag 0 is ignored).

Test Plan:
- Reset, then in_valid, kind 0, rs1/rs2 tags 0, vj_rf=5, vk_rf=7, rob_tag=3 -> rob_alloc=1, rf_rename_rd=rd; next cycle out_valid=1, out_to_lsb=0, out_dest=3, vj=5, vk=7, qj=qk=0.
- qj_rf=2, rob not ready, bus1 tag 2 value 0xAA and bus0 tag 2 value 0x55 same cycle -> out_vj=0x55, out_qj=0 (bus0 priority).
- Store issued with qk_rf=4 unresolved, out_ready=0 for 3 cycles, bus0 tag 4 value 9 in cycle 2 -> out_qk=0, out_vk=9 by cycle 3; rf_rename_rd=0; out_to_lsb=1.
- out_valid=1, out_ready=1, in_valid=1 for 4 cycles -> 4 accepts, 4 consecutive distinct out_dest, no bubbles; rob_full=1 -> in_ready=0, rob_alloc=0.
- flush while holding an entry with in_valid=1 -> out_valid=0 next cycle, no rob_alloc; rst_n low mid-stall -> out_valid=0 immediately (async).
- rdy=0 with in_valid=1 and a bus hit on the held tag -> no state change; after rdy=1 the snoop happens only if the bus is still valid.
